// File: rtl/raid_drive_model.sv
// raid_drive_model: drive-side responder for the RAID drive-controller interface.
// It accepts one-cycle write/read strobes and holds busy high for a programmable
// service latency. It stores words in a small array. Read data becomes valid in the
// first cycle that busy is low.
// Optional build macro: RAID_DRIVE_FAULT_INJ_EN. When defined, fault_inject flips
// bit 0 of the returned read word.
module raid_drive_model #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int WR_LAT = 4,
  parameter int RD_LAT = 3,
  parameter int SPINUP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        err,
  input  logic        fault_inject
);

  typedef enum logic [1:0] {S_SPINUP, S_IDLE, S_WRITE, S_READ} state_t;

  // Counter values at which each busy phase ends.
  localparam logic [7:0] WR_LAST   = 8'(WR_LAT - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);
  localparam logic [7:0] SPIN_LAST = 8'((SPINUP > 0) ? SPINUP - 1 : 0);
  localparam state_t     RST_STATE = (SPINUP > 0) ? S_SPINUP : S_IDLE;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_d;
  logic            accept;
  logic            wr_fire, rd_fire;
  logic            in_range;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rd_word;
  logic [31:0]     mem [DEPTH];

  assign in_range = (addr[31:AW] == '0);
  assign busy     = (state_q != S_IDLE);
  assign wr_fire  = (state_q == S_WRITE) && (cnt_q == 8'd0);
  assign rd_fire  = (state_q == S_READ)  && (cnt_q == 8'd0);

`ifdef RAID_DRIVE_FAULT_INJ_EN
  assign rd_word = mem[idx_q] ^ {31'd0, fault_inject};
`else
  // The port stays in the interface, but this build does not use it.
  logic unused_fault;
  assign unused_fault = fault_inject;
  assign rd_word      = mem[idx_q];
`endif

  // Control state, service counter and the error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= 8'd0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
    end
  end

  // Next-state logic. Spin-up counts up from 0, and service phases count down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_SPINUP: begin
        if (cnt_q == SPIN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_IDLE: begin
        if (w_en && r_en) begin
          err_d = 1'b1;
        end else if (w_en || r_en) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = w_en ? S_WRITE : S_READ;
            cnt_d   = w_en ? WR_LAST : RD_LAST;
          end
        end
      end
      S_WRITE, S_READ: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Capture the command index and write data when a command is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= addr[AW-1:0];
      wdata_q <= wr_data;
    end
  end

  // Commit the write at the final busy edge. A reset aborts the pending write.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) mem[idx_q] <= wdata_q;
  end

  // Read data updates only when a read completes, and it holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rd_data <= 32'd0;
    else if (rd_fire) rd_data <= rd_word;
  end

endmodule

// File: tb/tb_raid_drive_model.sv
// Directed bench for raid_drive_model with default parameters
// (DEPTH=16, WR_LAT=4, RD_LAT=3, SPINUP=8).
module tb_raid_drive_model;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_en, r_en, fault_inject;
  logic [31:0] addr, wr_data;
  logic [31:0] rd_data;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic        e;
    logic        chk;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [14];

  raid_drive_model dut (
    .clk(clk), .reset(reset), .w_en(w_en), .r_en(r_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .err(err),
    .fault_inject(fault_inject)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Count the busy-high cycles, starting at the current falling edge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one strobe, then check the err pulse, the busy length and the read data.
  task automatic do_cmd(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    w_en = v.w; r_en = v.r; addr = v.a; wr_data = v.d;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    check({nm, "_err"}, {31'd0, err}, {31'd0, v.e});
    count_busy(n);
    check({nm, "_busy_cycles"}, n, v.lat);
    if (v.e) begin
      @(negedge clk);
      check({nm, "_err_fall"}, {31'd0, err}, 32'd0);
    end
    if (v.chk) check({nm, "_rd_data"}, rd_data, v.rd);
  endtask

  task automatic spinup_check(input string nm);
    int n;
    logic err_seen;
    n = 0;
    err_seen = 1'b0;
    // The strobe is out of range during spin-up. The drive must ignore it silently.
    r_en = 1'b1; addr = 32'h0000_0100;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
      err_seen |= err;
      if (n == 4) r_en = 1'b0;
    end
    r_en = 1'b0;
    check({nm, "_cycles"}, n, 8);
    check({nm, "_err"}, {31'd0, err_seen}, 32'd0);
    check({nm, "_rd_data"}, rd_data, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   bc;
    logic es;

    vecs[0]  = '{1'b1, 1'b0, 32'd0,          32'h0000_0000, 4, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'd3,          32'hA5A5_1234, 4, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'd3,          32'h0,         3, 1'b0, 1'b1, 32'hA5A5_1234};
    vecs[3]  = '{1'b1, 1'b1, 32'd3,          32'h0,         0, 1'b1, 1'b1, 32'hA5A5_1234};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010,  32'h0,         0, 1'b1, 1'b1, 32'hA5A5_1234};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010,  32'h0BAD_BAD0, 0, 1'b1, 1'b1, 32'hA5A5_1234};
    vecs[6]  = '{1'b0, 1'b1, 32'd0,          32'h0,         3, 1'b0, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b1, 1'b0, 32'd5,          32'h2222_2222, 4, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'd15,         32'hFFFF_0000, 4, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'd15,         32'h0,         3, 1'b0, 1'b1, 32'hFFFF_0000};
    vecs[10] = '{1'b1, 1'b0, 32'd7,          32'h0000_00AA, 4, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'd2,          32'h0000_0010, 4, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h8000_0003,  32'h5555_5555, 0, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'd3,          32'h0,         3, 1'b0, 1'b1, 32'hA5A5_1234};

    reset = 1'b1; w_en = 1'b0; r_en = 1'b0; addr = 32'd0; wr_data = 32'd0;
    fault_inject = 1'b0;

    // Reset state and spin-up.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    spinup_check("spinup");

    // Main table of commands.
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      do_cmd(v, $sformatf("vec%0d", i));
    end

    // Strobes during a write busy window are ignored, and write data was latched.
    @(negedge clk);
    w_en = 1'b1; addr = 32'd9; wr_data = 32'h3333_3333;
    bc = 0; es = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bc += int'(busy);
      es |= err;
      case (i)
        0: begin w_en = 1'b1; addr = 32'd5; wr_data = 32'h1111_1111; end
        1: begin w_en = 1'b0; r_en = 1'b1; end
        2: begin r_en = 1'b0; wr_data = 32'd0; end
        default: ;
      endcase
    end
    check("ignore_busy_cycles", bc, 4);
    check("ignore_err", {31'd0, es}, 32'd0);
    v = '{1'b0, 1'b1, 32'd5, 32'h0, 3, 1'b0, 1'b1, 32'h2222_2222};
    do_cmd(v, "ignore_rd5");
    v = '{1'b0, 1'b1, 32'd9, 32'h0, 3, 1'b0, 1'b1, 32'h3333_3333};
    do_cmd(v, "latched_rd9");

    // Reset during a write aborts it. Address 7 keeps its old value.
    @(negedge clk);
    w_en = 1'b1; addr = 32'd7; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    w_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midwr_reset_busy", {31'd0, busy}, 32'd1);
    check("midwr_reset_rd_data", rd_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    spinup_check("respin");
    v = '{1'b0, 1'b1, 32'd7, 32'h0, 3, 1'b0, 1'b1, 32'h0000_00AA};
    do_cmd(v, "midwr_rd7");

    // Fault injection on a read of address 2, which holds 0x10.
    fault_inject = 1'b1;
`ifdef RAID_DRIVE_FAULT_INJ_EN
    v = '{1'b0, 1'b1, 32'd2, 32'h0, 3, 1'b0, 1'b1, 32'h0000_0011};
`else
    v = '{1'b0, 1'b1, 32'd2, 32'h0, 3, 1'b0, 1'b1, 32'h0000_0010};
`endif
    do_cmd(v, "fault_rd2");
    fault_inject = 1'b0;
    v = '{1'b0, 1'b1, 32'd2, 32'h0, 3, 1'b0, 1'b1, 32'h0000_0010};
    do_cmd(v, "clean_rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/raid_drive_model.md
Name: raid_drive_model

Overview:
- Single-drive responder: the drive-side end of the RAID drive-controller interface.
- Accepts one-cycle write/read strobes plus address and data from the RAID controller, then signals `busy` for a programmable service latency.
- Stores words in a small internal array and returns read data that is stable once `busy` drops.
- Four instances (one per drive slot) form the drive bank in system simulation and on FPGA.

Parameters:
- DEPTH, 16, number of 32-bit words stored; must be a power of 2.
- AW, 4, address bits used to index the array; AW = log2(DEPTH).
- WR_LAT, 4, cycles `busy` stays high for a write; legal range 1..255.
- RD_LAT, 3, cycles `busy` stays high for a read; legal range 1..255.
- SPINUP, 8, cycles `busy` stays high after reset release; 0 disables spin-up.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- w_en  in  1  write strobe (controller w_drives).
- r_en  in  1  read strobe (controller r_drives).
- addr  in  32  word address (controller drive_addr).
- wr_data  in  32  write data (controller w_drive_dataN).
- rd_data  out  32  read data (to controller r_drive_dataN).
- busy  out  1  drive busy (to controller busy_driveN).
- err  out  1  one-cycle pulse: rejected command.
- fault_inject  in  1  read-corruption request; used only with the optional feature.

Behaviour:
- Reset (async):
  - busy = (SPINUP>0), rd_data = 0, err = 0.
  - State = SPINUP if SPINUP>0, else IDLE; counter = 0.
  - Array contents are not reset and are unaffected by reset.
- States: SPINUP, IDLE, WRITE, READ. 8-bit down-counter `cnt`.
- SPINUP: busy=1 for exactly SPINUP cycles after reset deassertion, then -> IDLE, busy=0. Strobes are ignored and no err is raised.
- IDLE, sampled at rising edge k:
  - w_en=1, r_en=0, addr[31:AW]==0: latch addr[AW-1:0] and wr_data; -> WRITE, cnt=WR_LAT-1, busy=1 after edge k.
  - r_en=1, w_en=0, addr[31:AW]==0: latch index; -> READ, cnt=RD_LAT-1, busy=1 after edge k.
  - w_en=1 and r_en=1: rejected; err=1 for one cycle; state, busy and array unchanged.
  - Either strobe with addr[31:AW]!=0 (out of range): rejected; err=1 for one cycle; no busy, no array change, rd_data unchanged.
- WRITE/READ:
  - cnt decrements each edge while cnt!=0. At the edge where cnt==0: -> IDLE, busy=0.
  - busy is high for exactly WR_LAT or RD_LAT cycles (edges k+1..k+LAT).
  - WRITE: array[index] <= latched data at the final edge (k+LAT). A read accepted afterwards returns the new value.
  - READ: rd_data <= array[index] at the final edge, so data is valid the first cycle busy is low. rd_data holds until the next completed read.
- Strobes arriving while busy (WRITE/READ/SPINUP) are ignored silently; no err, no queueing. The controller re-asserting r_en during its wait phase relies on this.
- The first strobe sampled in IDLE is serviced. A strobe at the same edge busy falls is not accepted; it must arrive in IDLE.
- Reset mid-WRITE aborts the write: the array is not updated. Reset mid-READ: rd_data = 0.
- Latched write data is captured at acceptance; later wr_data changes are ignored.
- Timing contract: busy rises in the cycle after the strobe and drops with valid rd_data. This is what the RAID controller's WRITE_FINISH / READ_WAIT sequencing requires.

Optional Feature:
- Macro: RAID_DRIVE_FAULT_INJ_EN.
- Defined: at READ completion, if fault_inject==1, rd_data <= array[index] ^ 32'h0000_0001. The array is unaltered. Used to exercise the controller's RAID1 err and RAID5 parity paths.
- Undefined: fault_inject is ignored (port kept for a stable interface); rd_data is always the stored word.

Test Plan:
- Spin-up: reset 2 cycles, release; SPINUP=8 -> busy=1 for exactly 8 cycles after release, then 0; rd_data=0, err=0.
- Write/read: write addr=3, data=32'hA5A5_1234 -> busy high 4 cycles. Then read addr=3 -> busy high 3 cycles; rd_data=32'hA5A5_1234 the first cycle busy=0, and held.
- Ignore while busy: during a write busy window, pulse w_en addr=5 data=32'h1111_1111 and r_en. Afterwards read addr=5 after a prior write of 32'h2222_2222 -> returns 32'h2222_2222; no err.
- Rejects: w_en=r_en=1 -> err 1-cycle pulse, busy stays 0. Read addr=32'h0000_0010 (DEPTH=16) -> err pulse, no busy, rd_data unchanged.
- Reset mid-write:
  - Write addr=7 data=32'hDEAD_BEEF after addr 7 holds 32'h0000_00AA.
  - Reset on busy cycle 2 -> busy=1 (spin-up).
  - After spin-up, read addr 7 -> 32'h0000_00AA.
- Fault (RAID_DRIVE_FAULT_INJ_EN defined): addr 2 holds 32'h0000_0010; read with fault_inject=1 -> rd_data=32'h0000_0011. Re-read with fault_inject=0 -> 32'h0000_0010.
